// File: rtl/afe_pkg.sv
// Shared parameters, types and arithmetic helpers for the pulse-oximeter AFE model.
package afe_pkg;

    localparam int RED_DC_DEF     = 16;
    localparam int RED_AC_DEF     = 24;
    localparam int IR_DC_DEF      = 20;
    localparam int IR_AC_DEF      = 32;
    localparam int COMP_STEP_DEF  = 2;
    localparam int SAMPLE_DIV_DEF = 16;
    localparam int SETTLE_CYC_DEF = 8;
    localparam int BEAT_DIV_DEF   = 64;

    localparam int PHOTO_W = 13;
    localparam int DIFF_W  = 14;
    localparam int AMP_W   = 19;
    localparam int PHASE_W = 9;

    localparam logic [7:0]              ADC_MID  = 8'd128;
    localparam logic signed [AMP_W-1:0] AMP_BIAS = 19'sd128;
    localparam logic signed [AMP_W-1:0] AMP_ZERO = 19'sd0;
    localparam logic signed [AMP_W-1:0] AMP_TOP  = 19'sd255;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        TRACK  = 1'b1
    } afe_state_e;

    typedef struct packed {
        logic       led_red;
        logic       led_ir;
        logic [3:0] drive;
        logic [6:0] dc_comp;
        logic [3:0] gain;
    } afe_cfg_t;

    // Photocurrent of one LED: DC level scaled by drive plus the scaled pulsatile part.
    function automatic logic [PHOTO_W-1:0] led_term(input logic [7:0] dc,
                                                    input logic [7:0] ac,
                                                    input logic [3:0] drive,
                                                    input logic [7:0] tri_v);
        logic [PHOTO_W-1:0] dc_prod;
        logic [15:0]        ac_prod;
        dc_prod = PHOTO_W'(dc) * PHOTO_W'(drive);
        ac_prod = 16'(ac) * 16'(tri_v);
        return dc_prod + PHOTO_W'(ac_prod[15:8]);
    endfunction

    // Re-centre the amplified signal on mid-scale and saturate to the 8-bit ADC range.
    function automatic logic [7:0] clamp_code(input logic signed [AMP_W-1:0] amp);
        logic signed [AMP_W-1:0] biased;
        logic [7:0]              code;
        biased = amp + AMP_BIAS;
        if (biased < AMP_ZERO) begin
            code = 8'd0;
        end else if (biased > AMP_TOP) begin
            code = 8'd255;
        end else begin
            code = biased[7:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/afe_emulator_wave.sv
// Heartbeat waveform source: slow phase counter folded into a 0..255 triangle.
module ppg_wave_gen
    import afe_pkg::*;
#(
    parameter int BEAT_DIV = BEAT_DIV_DEF
) (
    input  logic       CLK,
    input  logic       rst,
    output logic [7:0] tri_level
);

    localparam int              BW        = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [BW-1:0]   BEAT_LAST = BW'(BEAT_DIV - 1);
    localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);

    logic [BW-1:0]      beat_cnt_r;
    logic [PHASE_W-1:0] phase_r;
    logic [7:0]         tri_s;

    // Beat prescaler and phase counter; the phase wraps 511 -> 0 naturally.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            beat_cnt_r <= '0;
            phase_r    <= '0;
        end else if (beat_cnt_r == BEAT_LAST) begin
            beat_cnt_r <= '0;
            phase_r    <= phase_r + 9'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
        end
    end

    // Rising half follows the phase, falling half mirrors it.
    always_comb begin
        tri_s = 8'd0;
        if (phase_r[8]) begin
            tri_s = ~phase_r[7:0];
        end else begin
            tri_s = phase_r[7:0];
        end
    end

    assign tri_level = tri_s;

endmodule

// File: rtl/afe_emulator.sv
// Closed-loop stand-in for the pulse-oximeter analog front end: turns LED/gain/
// compensation settings into an 8-bit sample stream, blanking samples while settling.
module afe_emulator
    import afe_pkg::*;
#(
    parameter int RED_DC     = RED_DC_DEF,
    parameter int RED_AC     = RED_AC_DEF,
    parameter int IR_DC      = IR_DC_DEF,
    parameter int IR_AC      = IR_AC_DEF,
    parameter int COMP_STEP  = COMP_STEP_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int BEAT_DIV   = BEAT_DIV_DEF
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       ADC_valid
);

    localparam logic [7:0]         RED_DC_B    = 8'(RED_DC);
    localparam logic [7:0]         RED_AC_B    = 8'(RED_AC);
    localparam logic [7:0]         IR_DC_B     = 8'(IR_DC);
    localparam logic [7:0]         IR_AC_B     = 8'(IR_AC);
    localparam logic [PHOTO_W-1:0] COMP_STEP_B = PHOTO_W'(COMP_STEP);

    localparam int              SMP_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_ONE  = SMP_W'(1);

    localparam int              SET_W       = $clog2(SETTLE_CYC + 1) + 1;
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYC);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);

    afe_cfg_t                 cfg_in_s;
    afe_cfg_t                 cfg_r;
    afe_state_e               state_r;
    logic [SET_W-1:0]         settle_cnt_r;
    logic [SMP_W-1:0]         sample_cnt_r;
    logic [7:0]               adc_r;
    logic                     adc_valid_r;

    logic [7:0]               tri_s;
    logic                     change_s;
    logic                     tick_s;
    logic                     accept_s;
    logic [PHOTO_W-1:0]       red_s;
    logic [PHOTO_W-1:0]       ir_s;
    logic [PHOTO_W-1:0]       photo_s;
    logic [PHOTO_W-1:0]       comp_s;
    logic [4:0]               gain_s;
    logic signed [DIFF_W-1:0] diff_s;
    logic signed [AMP_W-1:0]  amp_s;
    logic [7:0]               code_s;

    ppg_wave_gen #(
        .BEAT_DIV (BEAT_DIV)
    ) u_wave (
        .CLK       (CLK),
        .rst       (rst),
        .tri_level (tri_s)
    );

    // Signal chain, always computed from the captured configuration.
    always_comb begin
        cfg_in_s.led_red = LED_RED;
        cfg_in_s.led_ir  = LED_IR;
        cfg_in_s.drive   = LED_DRIVE;
        cfg_in_s.dc_comp = DC_Comp;
        cfg_in_s.gain    = PGA_Gain;

        change_s = (cfg_in_s != cfg_r);
        tick_s   = (sample_cnt_r == SMP_LAST);

        red_s = 13'd0;
        if (cfg_r.led_red) begin
            red_s = led_term(RED_DC_B, RED_AC_B, cfg_r.drive, tri_s);
        end else begin
            red_s = 13'd0;
        end

        ir_s = 13'd0;
        if (cfg_r.led_ir) begin
            ir_s = led_term(IR_DC_B, IR_AC_B, cfg_r.drive, tri_s);
        end else begin
            ir_s = 13'd0;
        end

        photo_s = red_s + ir_s;
        comp_s  = PHOTO_W'(cfg_r.dc_comp) * COMP_STEP_B;
        diff_s  = $signed({1'b0, photo_s}) - $signed({1'b0, comp_s});
        gain_s  = {1'b0, cfg_r.gain} + 5'd1;
        amp_s   = AMP_W'(diff_s) * $signed(AMP_W'(gain_s));
        code_s  = clamp_code(amp_s);

        // A change on the same edge as a tick wins: the sample is dropped.
        accept_s = tick_s && (state_r == TRACK) && !change_s;
    end

    // Configuration capture register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cfg_r <= '0;
        end else begin
            cfg_r <= cfg_in_s;
        end
    end

    // Free-running conversion timer, deliberately untouched by configuration changes.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sample_cnt_r <= '0;
        end else if (tick_s) begin
            sample_cnt_r <= '0;
        end else begin
            sample_cnt_r <= sample_cnt_r + SMP_ONE;
        end
    end

    // Settle/track control; any change restarts the full settle window.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r      <= SETTLE;
            settle_cnt_r <= SETTLE_INIT;
        end else if (change_s) begin
            state_r      <= SETTLE;
            settle_cnt_r <= SETTLE_INIT;
        end else begin
            case (state_r)
                SETTLE: begin
                    if (settle_cnt_r > SET_ONE) begin
                        settle_cnt_r <= settle_cnt_r - SET_ONE;
                    end else begin
                        settle_cnt_r <= '0;
                        state_r      <= TRACK;
                    end
                end
                TRACK: begin
                    state_r      <= TRACK;
                    settle_cnt_r <= '0;
                end
                default: begin
                    state_r      <= SETTLE;
                    settle_cnt_r <= SETTLE_INIT;
                end
            endcase
        end
    end

    // Sample register: updates only on accepted ticks and holds otherwise.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            adc_r       <= ADC_MID;
            adc_valid_r <= 1'b0;
        end else begin
            adc_valid_r <= accept_s;
            if (accept_s) begin
                adc_r <= code_s;
            end
        end
    end

    assign ADC       = adc_r;
    assign ADC_valid = adc_valid_r;

endmodule

// File: tb/tb_afe_emulator.sv
// Scoreboard bench for afe_emulator: stimulus pushes expected samples, a monitor pops them on ADC_valid.
module tb_afe_emulator;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       LED_RED = 1'b0;
    logic       LED_IR = 1'b0;
    logic [3:0] LED_DRIVE = 4'd0;
    logic [6:0] DC_Comp = 7'd0;
    logic [3:0] PGA_Gain = 4'd0;
    logic [7:0] ADC;
    logic       ADC_valid;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc;
    bit         mon_on = 1'b1;
    logic [7:0] sb_q[$];
    int         vt_q[$];

    afe_emulator dut (
        .CLK       (CLK),
        .rst       (rst),
        .LED_RED   (LED_RED),
        .LED_IR    (LED_IR),
        .LED_DRIVE (LED_DRIVE),
        .DC_Comp   (DC_Comp),
        .PGA_Gain  (PGA_Gain),
        .ADC       (ADC),
        .ADC_valid (ADC_valid)
    );

    always #5 CLK = ~CLK;

    // Cycles since reset release: edge k leaves cyc == k.
    always @(posedge CLK or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp_v, cyc);
    endtask

    // Monitor: every valid must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!rst && mon_on && ADC_valid === 1'b1) begin
            vt_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: ADC_valid=1 ADC=%0d, expected no valid (cyc %0d)", ADC, cyc);
            end else begin
                check("adc_value", int'(ADC), int'(sb_q.pop_front()));
            end
        end
    end

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge CLK); #1;
            k++;
        end
        check({name, "_drained"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic apply(input string name, input logic red, input logic ir,
                         input logic [3:0] drv, input logic [6:0] comp,
                         input logic [3:0] gain, input logic [7:0] exp_v, input int n);
        int v0;
        int t_chg;
        LED_RED   = red;
        LED_IR    = ir;
        LED_DRIVE = drv;
        DC_Comp   = comp;
        PGA_Gain  = gain;
        t_chg = cyc + 1;
        v0    = vt_q.size();
        for (int i = 0; i < n; i++) sb_q.push_back(exp_v);
        drain(name, 16 + 16 * n);
        if (vt_q.size() > v0)
            check({name, "_first_valid_cyc"}, vt_q[v0], ((t_chg + 8) / 16 + 1) * 16);
    endtask

    task automatic reset_check(input string name);
        int v0;
        rst       = 1'b1;
        LED_RED   = 1'b0;
        LED_IR    = 1'b0;
        LED_DRIVE = 4'd0;
        DC_Comp   = 7'd0;
        PGA_Gain  = 4'd0;
        sb_q.delete();
        #1;
        check({name, "_adc"}, int'(ADC), 128);
        check({name, "_valid"}, int'(ADC_valid), 0);
        @(negedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        v0 = vt_q.size();
        sb_q.push_back(8'd128);
        drain(name, 40);
        if (vt_q.size() > v0) check({name, "_first_valid_cyc"}, vt_q[v0], 16);
    endtask

    initial begin
        #2;
        reset_check("por");

        apply("red", 1'b1, 1'b0, 4'd10, 7'd40, 4'd0, 8'd208, 3);
        check("red_interval", vt_q[$] - vt_q[$-1], 16);
        apply("red_sat_hi", 1'b1, 1'b0, 4'd10, 7'd40, 4'd15, 8'd255, 2);
        apply("red_sat_lo", 1'b1, 1'b0, 4'd10, 7'd127, 4'd3, 8'd0, 2);
        apply("red_mid", 1'b1, 1'b0, 4'd10, 7'd70, 4'd0, 8'd148, 1);

        repeat (3) begin @(negedge CLK); #1; end
        apply("midstream_gain", 1'b1, 1'b0, 4'd10, 7'd70, 4'd1, 8'd168, 1);

        // Change lands exactly on a tick edge.
        while (cyc % 16 != 15) begin @(negedge CLK); #1; end
        PGA_Gain = 4'd2;
        @(negedge CLK); #1;
        check("collision_no_valid", int'(ADC_valid), 0);
        check("collision_adc_hold", int'(ADC), 168);
        begin
            int v0;
            int t_chg;
            t_chg = cyc;
            v0    = vt_q.size();
            sb_q.push_back(8'd188);
            drain("collision", 40);
            if (vt_q.size() > v0) check("collision_first_valid_cyc", vt_q[v0], t_chg + 16);
        end

        reset_check("rst2");
        apply("ir_balance", 1'b0, 1'b1, 4'd10, 7'd100, 4'd0, 8'd128, 2);

        // Let the waveform climb to its peak region (tri >= 248).
        mon_on = 1'b0;
        while (cyc < 15900) begin @(negedge CLK); #1; end
        mon_on = 1'b1;
        apply("ir_peak_gain1", 1'b0, 1'b1, 4'd10, 7'd100, 4'd1, 8'd190, 1);
        apply("ir_peak", 1'b0, 1'b1, 4'd10, 7'd100, 4'd0, 8'd159, 2);

        PGA_Gain = 4'd5;
        repeat (3) begin @(negedge CLK); #1; end
        reset_check("mid_settle_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/afe_emulator.md
# afe_emulator

Synthesizable model of the pulse-oximeter analog front end: it consumes the controller's LED, LED-drive, DC-compensation and PGA-gain outputs and produces the 8-bit ADC sample stream the controller calibrates against. It models a triangular heartbeat waveform on a per-LED DC level, then applies DC subtraction, PGA gain and ADC clamping. Settling after any configuration change is modelled by suppressing samples. It sits opposite the controller in closed-loop benches and FPGA bring-up, replacing the physical AFE.

## Interface
- RED_DC, 16: red photocurrent per LED_DRIVE step (8 bit)
- RED_AC, 24: red pulsatile amplitude at full waveform (8 bit)
- IR_DC, 20: IR photocurrent per LED_DRIVE step (8 bit)
- IR_AC, 32: IR pulsatile amplitude (8 bit)
- COMP_STEP, 2: photocurrent removed per DC_Comp LSB
- SAMPLE_DIV, 16: clock cycles per ADC conversion
- SETTLE_CYC, 8: settle window after a configuration change
- BEAT_DIV, 64: clock cycles per waveform phase step
- CLK  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- LED_RED  input  1  red LED on
- LED_IR  input  1  IR LED on
- LED_DRIVE  input  4  LED current setting
- DC_Comp  input  7  DC compensation code
- PGA_Gain  input  4  gain code, gain = PGA_Gain+1
- ADC  output  8  converted sample
- ADC_valid  output  1  one-cycle strobe, ADC just updated

## Operation
- cfg register: captures {LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain} every cycle. Inputs != cfg is a change event.
- Waveform: 9-bit phase increments every BEAT_DIV cycles and wraps 511→0. tri = phase[8] ? ~phase[7:0] : phase[7:0], range 0..255.
- photo (unsigned 13 bit):
  - red term = RED_DC*LED_DRIVE + ((RED_AC*tri)>>8) if cfg LED_RED, else 0.
  - IR term formed the same way from the IR parameters.
  - photo = sum of both terms; both LEDs on gives the sum.
- comp = DC_Comp*COMP_STEP.
- diff = photo − comp, signed 14 bit.
- amp = diff*(PGA_Gain+1), signed 19 bit.
- code = 128 + amp, clamped to 0..255.
- All arithmetic uses cfg values, never raw inputs.
- FSM states:
  - SETTLE: settle counter > 0, decremented each cycle. Conversions are suppressed. Exit to TRACK when the counter reaches 0.
  - TRACK: on each sample tick, ADC <= code and ADC_valid = 1.
- Any change event, in any state, reloads the settle counter to SETTLE_CYC and enters SETTLE. A change during SETTLE extends the window.
- Sample counter free-runs 0..SAMPLE_DIV−1. Tick when the counter = SAMPLE_DIV−1. The counter is never reset by change events.

## Timing
- Reset values: ADC=128, ADC_valid=0, phase=0, sample counter=0, cfg=0, state SETTLE with counter SETTLE_CYC.
- ADC and ADC_valid are registered and change on the tick edge. ADC holds between ticks.
- ADC_valid is high for exactly one cycle per accepted tick.
- Change event and tick in the same cycle: the change wins. No valid; ADC holds.
- A change detected at edge t (cfg updated at t) suppresses ticks through t+SETTLE_CYC. The first valid is the first tick after that.
- Worst-case change-to-valid: SETTLE_CYC+SAMPLE_DIV cycles.
- Reset asserted mid-operation clears immediately, with no pending valid.
- Clamp applies before truncation; no wrap at 0 or 255.

## Structure
- Package afe_pkg: parameter defaults, state enum {SETTLE, TRACK}, widths of photo/diff/amp.
- Sub-module ppg_wave_gen: phase counter plus triangle output tri[7:0]. Everything else stays in afe_emulator.

## Test plan
- Reset check: rst high then released → ADC=128, ADC_valid=0. First valid at the first tick after SETTLE_CYC.
- Red scenario (BEAT_DIV large, tri=0): LED_RED=1, LED_DRIVE=10, DC_Comp=40, PGA_Gain=0 → ADC=208, valid every 16 cycles.
- Red saturation: same settings with PGA_Gain=15 → ADC=255. Same settings with DC_Comp=127, PGA_Gain=3 → diff=−94, ADC=0.
- IR balance: LED_IR=1, LED_DRIVE=10, DC_Comp=100, PGA_Gain=0, tri=0 → ADC=128. With tri=255 → ADC=159.
- Mid-stream change: change PGA_Gain during TRACK → no ADC_valid for SETTLE_CYC cycles. First valid within 24 cycles, carrying the new gain.
- Collision and reset:
  - Change coincident with a tick → no valid that cycle.
  - rst pulse mid-settle → outputs return to reset values.
